// File: rtl/mux_stream_pkg.sv
// ---------------------------------------------------------------------------
// mux_stream_pkg
// Shared definitions for the N:1 registered stream multiplexer.
//   MODE_SEL / MODE_RR : values of the top-level 'mode' input
//   lock_state_t       : packet-lock FSM states (used when MUX_STREAM_LOCK_EN
//                        is defined)
//   onehot_to_idx      : one-hot (up to 16 bits) to binary index
// ---------------------------------------------------------------------------
package mux_stream_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

    // OR-reduction form: with a one-hot (or zero) input this is exact and
    // maps to a small OR tree rather than a priority chain.
    function automatic logic [3:0] onehot_to_idx(input logic [15:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (oh[i]) begin
                idx = idx | 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. Grants the first requester found
// searching ptr, ptr+1, ... modulo N.
// Ports:
//   req  in  N     request vector
//   ptr  in  SELW  highest-priority index this cycle (must be < N)
//   gnt  out N     one-hot grant, zero when no request
// ---------------------------------------------------------------------------
module rr_arbiter
    import mux_stream_pkg::*;
#(
    parameter  int N    = 4,
    localparam int SELW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [N-1:0]    gnt
);

    // pos[i] is the channel examined at search step i: (ptr + i) mod N.
    logic [SELW-1:0] pos [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_pos
            logic [SELW:0] sum;
            logic [SELW:0] wrapped;
            assign sum     = {1'b0, ptr} + (SELW+1)'(gi);
            assign wrapped = (sum >= (SELW+1)'(N)) ? (sum - (SELW+1)'(N)) : sum;
            assign pos[gi] = wrapped[SELW-1:0];
        end
    endgenerate

    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[pos[i]]) begin
                gnt[pos[i]] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_nx1_stream.sv
// ---------------------------------------------------------------------------
// mux_nx1_stream
// N-input, W-bit registered stream multiplexer with valid/ready handshakes.
// A channel is chosen by 'sel' (MODE_SEL) or by round-robin (MODE_RR) and the
// chosen beat is captured into a one-deep output register (latency 1 clk,
// full throughput).
//
// Optional build macro: MUX_STREAM_LOCK_EN
//   When defined, a packet-lock FSM keeps the grant on the channel that
//   started a multi-beat packet until its last beat has transferred.
//
// Ports:
//   clk       in   1      clock, rising edge
//   rst       in   1      asynchronous reset, active-high
//   mode      in   1      MODE_SEL (0) or MODE_RR (1)
//   sel       in   SELW   channel select for MODE_SEL
//   in_valid  in   N      per-channel valid
//   in_data   in   N*W    channel k at [k*W +: W]
//   in_last   in   N      per-channel end-of-packet
//   in_ready  out  N      per-channel ready (one-hot or zero)
//   y_valid   out  1      output beat valid
//   y_data    out  W      output data
//   y_last    out  1      end-of-packet of the output beat
//   y_ch      out  SELW   source channel of the output beat
//   y_ready   in   1      downstream ready
// ---------------------------------------------------------------------------
module mux_nx1_stream
    import mux_stream_pkg::*;
#(
    parameter  int N    = 4,
    parameter  int W    = 8,
    localparam int SELW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mode,
    input  logic [SELW-1:0] sel,
    input  logic [N-1:0]    in_valid,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_last,
    output logic [N-1:0]    in_ready,
    output logic            y_valid,
    output logic [W-1:0]    y_data,
    output logic            y_last,
    output logic [SELW-1:0] y_ch,
    input  logic            y_ready
);

    // -----------------------------------------------------------------------
    // Channel unpacking
    // -----------------------------------------------------------------------
    logic [W-1:0] ch_data [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_unpack
            assign ch_data[gi] = in_data[gi*W +: W];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic            y_valid_reg, y_valid_next;
    logic [W-1:0]    y_data_reg,  y_data_next;
    logic            y_last_reg,  y_last_next;
    logic [SELW-1:0] y_ch_reg,    y_ch_next;
    logic [SELW-1:0] rr_ptr_reg,  rr_ptr_next;

    // -----------------------------------------------------------------------
    // Arbitration
    // -----------------------------------------------------------------------
    logic [N-1:0]    grant_sel;
    logic [N-1:0]    grant_rr;
    logic [N-1:0]    grant_arb;
    logic [N-1:0]    grant;
    logic            load;
    logic            xfer;
    logic [SELW-1:0] xfer_idx;

    // A select value outside 0..N-1 (possible when N is not a power of two)
    // grants nothing, so the output simply drains.
    always_comb begin
        grant_sel = '0;
        if ((32'(sel) < N) && in_valid[sel]) begin
            grant_sel[sel] = 1'b1;
        end
    end

    rr_arbiter #(
        .N (N)
    ) u_rr_arbiter (
        .req (in_valid),
        .ptr (rr_ptr_reg),
        .gnt (grant_rr)
    );

    assign grant_arb = (mode == MODE_RR) ? grant_rr : grant_sel;

`ifdef MUX_STREAM_LOCK_EN
    // -----------------------------------------------------------------------
    // Packet lock FSM: state register / next-state / output (grant) logic
    // -----------------------------------------------------------------------
    lock_state_t     lock_state_reg, lock_state_next;
    logic [SELW-1:0] lk_reg, lk_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_state_reg <= UNLOCKED;
            lk_reg         <= '0;
        end else begin
            lock_state_reg <= lock_state_next;
            lk_reg         <= lk_next;
        end
    end

    // While LOCKED the only possible transfer is from lk_reg, so in_last at
    // xfer_idx is the locked channel's last flag.
    always_comb begin
        lock_state_next = lock_state_reg;
        lk_next         = lk_reg;
        case (lock_state_reg)
            UNLOCKED: begin
                if (xfer && !in_last[xfer_idx]) begin
                    lock_state_next = LOCKED;
                    lk_next         = xfer_idx;
                end
            end
            LOCKED: begin
                if (xfer && in_last[xfer_idx]) begin
                    lock_state_next = UNLOCKED;
                end
            end
            default: begin
                lock_state_next = UNLOCKED;
            end
        endcase
    end

    always_comb begin
        grant = grant_arb;
        if (lock_state_reg == LOCKED) begin
            grant = '0;
            if (in_valid[lk_reg]) begin
                grant[lk_reg] = 1'b1;
            end
        end
    end
`else
    assign grant = grant_arb;
`endif

    // -----------------------------------------------------------------------
    // Handshake
    // -----------------------------------------------------------------------
    // The output register can accept a beat when it is empty or being drained
    // this cycle. Readies are held low while reset is asserted so upstream
    // sees no acceptance during the asynchronous reset window.
    assign load     = !y_valid_reg || y_ready;
    assign in_ready = (load && !rst) ? grant : '0;
    assign xfer     = |in_ready;
    assign xfer_idx = SELW'(onehot_to_idx(16'(in_ready)));

    // -----------------------------------------------------------------------
    // Output register and round-robin pointer
    // -----------------------------------------------------------------------
    always_comb begin
        y_valid_next = y_valid_reg;
        y_data_next  = y_data_reg;
        y_last_next  = y_last_reg;
        y_ch_next    = y_ch_reg;
        rr_ptr_next  = rr_ptr_reg;
        if (xfer) begin
            y_valid_next = 1'b1;
            y_data_next  = ch_data[xfer_idx];
            y_last_next  = in_last[xfer_idx];
            y_ch_next    = xfer_idx;
            rr_ptr_next  = (xfer_idx == SELW'(N-1)) ? '0 : (xfer_idx + SELW'(1));
        end else if (y_ready) begin
            // Drained with nothing to replace it; payload fields keep their
            // last value, only valid drops.
            y_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_valid_reg <= 1'b0;
            y_data_reg  <= '0;
            y_last_reg  <= 1'b0;
            y_ch_reg    <= '0;
            rr_ptr_reg  <= '0;
        end else begin
            y_valid_reg <= y_valid_next;
            y_data_reg  <= y_data_next;
            y_last_reg  <= y_last_next;
            y_ch_reg    <= y_ch_next;
            rr_ptr_reg  <= rr_ptr_next;
        end
    end

    assign y_valid = y_valid_reg;
    assign y_data  = y_data_reg;
    assign y_last  = y_last_reg;
    assign y_ch    = y_ch_reg;

endmodule

// File: tb/tb_mux_nx1_stream.sv
// ---------------------------------------------------------------------------
// tb_mux_nx1_stream
// Directed, table-driven bench for mux_nx1_stream (N=4, W=8) plus a second
// instance with N=3 for the out-of-range select case.
// ---------------------------------------------------------------------------
module tb_mux_nx1_stream;

    logic clk;
    logic rst;

    // N=4 instance
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_last;
    logic [3:0]  in_ready;
    logic        y_valid;
    logic [7:0]  y_data;
    logic        y_last;
    logic [1:0]  y_ch;
    logic        y_ready;

    // N=3 instance
    logic        mode3;
    logic [1:0]  sel3;
    logic [2:0]  in_valid3;
    logic [23:0] in_data3;
    logic [2:0]  in_last3;
    logic [2:0]  in_ready3;
    logic        y_valid3;
    logic [7:0]  y_data3;
    logic        y_last3;
    logic [1:0]  y_ch3;
    logic        y_ready3;

    int checks;
    int errors;

    mux_nx1_stream #(.N(4), .W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode),
        .sel      (sel),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_last  (in_last),
        .in_ready (in_ready),
        .y_valid  (y_valid),
        .y_data   (y_data),
        .y_last   (y_last),
        .y_ch     (y_ch),
        .y_ready  (y_ready)
    );

    mux_nx1_stream #(.N(3), .W(8)) dut3 (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode3),
        .sel      (sel3),
        .in_valid (in_valid3),
        .in_data  (in_data3),
        .in_last  (in_last3),
        .in_ready (in_ready3),
        .y_valid  (y_valid3),
        .y_data   (y_data3),
        .y_last   (y_last3),
        .y_ch     (y_ch3),
        .y_ready  (y_ready3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    typedef struct {
        logic       mode;
        logic [1:0] sel;
        logic [3:0] valid;
        logic       yr;
        logic [3:0] rdy;
        logic       yv;
        logic [1:0] ch;
        logic [7:0] data;
    } vec_t;

    localparam int NV = 20;
    vec_t tbl [NV];

    int         ch0_beat;
    logic [1:0] exp_ch_seq [4];
    logic       exp_last;

    initial begin
        // mode sel valid yr | in_ready yv ch data   (rr_ptr starts at 0)
        tbl[0]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0};
        tbl[1]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1};
        tbl[2]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2};
        tbl[3]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3};
        tbl[4]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0};
        tbl[5]  = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1};
        tbl[6]  = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3};
        tbl[7]  = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1};
        tbl[8]  = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3};
        tbl[9]  = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2};
        tbl[10] = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2};
        tbl[11] = '{1'b0, 2'd3, 4'b0111, 1'b1, 4'b0000, 1'b0, 2'd2, 8'hA2};
        tbl[12] = '{1'b0, 2'd3, 4'b0111, 1'b1, 4'b0000, 1'b0, 2'd2, 8'hA2};
        tbl[13] = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 8'hA2};
        tbl[14] = '{1'b0, 2'd1, 4'b1111, 1'b0, 4'b0010, 1'b1, 2'd1, 8'hA1};
        tbl[15] = '{1'b0, 2'd1, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, 8'hA1};
        tbl[16] = '{1'b0, 2'd1, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, 8'hA1};
        tbl[17] = '{1'b0, 2'd1, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, 8'hA1};
        tbl[18] = '{1'b0, 2'd3, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3};
        tbl[19] = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, 8'hA3};

`ifdef MUX_STREAM_LOCK_EN
        exp_ch_seq = '{2'd0, 2'd0, 2'd0, 2'd1};
`else
        exp_ch_seq = '{2'd0, 2'd1, 2'd0, 2'd1};
`endif

        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        mode      = 1'b0;
        sel       = 2'd0;
        in_valid  = 4'b0000;
        in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        in_last   = 4'b1111;
        y_ready   = 1'b0;
        mode3     = 1'b0;
        sel3      = 2'd0;
        in_valid3 = 3'b000;
        in_data3  = {8'hB2, 8'hB1, 8'hB0};
        in_last3  = 3'b111;
        y_ready3  = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_y_valid", 32'(y_valid), 32'd0);
        chk("reset_y_ch", 32'(y_ch), 32'd0);
        rst = 1'b0;

        // Stall a beat in the output register, then reset between edges.
        mode     = 1'b0;
        sel      = 2'd0;
        in_valid = 4'b0001;
        y_ready  = 1'b0;
        @(posedge clk);
        #1;
        chk("stall_setup_valid", 32'(y_valid), 32'd1);
        chk("stall_setup_data", 32'(y_data), 32'hA0);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_y_valid", 32'(y_valid), 32'd0);
        chk("async_rst_y_data", 32'(y_data), 32'd0);
        chk("async_rst_y_last", 32'(y_last), 32'd0);
        chk("async_rst_y_ch", 32'(y_ch), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 4'b0000;

        // Table-driven vectors
        for (int i = 0; i < NV; i++) begin
            mode     = tbl[i].mode;
            sel      = tbl[i].sel;
            in_valid = tbl[i].valid;
            y_ready  = tbl[i].yr;
            #1;
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_y_valid", i), 32'(y_valid), 32'(tbl[i].yv));
            chk($sformatf("v%0d_y_ch", i), 32'(y_ch), 32'(tbl[i].ch));
            chk($sformatf("v%0d_y_data", i), 32'(y_data), 32'(tbl[i].data));
            chk($sformatf("v%0d_y_last", i), 32'(y_last), 32'd1);
        end

        // Multi-beat packet on ch0 competing with ch1 (rr_ptr is 0 here).
        mode     = 1'b1;
        in_valid = 4'b0011;
        y_ready  = 1'b1;
        ch0_beat = 0;
        for (int c = 0; c < 4; c++) begin
            in_last = {2'b11, 1'b1, (ch0_beat == 2)};
            exp_last = (exp_ch_seq[c] == 2'd1) ? 1'b1 : (ch0_beat == 2);
            @(posedge clk);
            #1;
            chk($sformatf("pkt%0d_y_ch", c), 32'(y_ch), 32'(exp_ch_seq[c]));
            chk($sformatf("pkt%0d_y_last", c), 32'(y_last), 32'(exp_last));
            if (exp_ch_seq[c] == 2'd0) begin
                ch0_beat++;
            end
        end
        in_valid = 4'b0000;
        in_last  = 4'b1111;

        // N=3: select value 3 is out of range and grants nothing.
        mode3     = 1'b0;
        sel3      = 2'd3;
        in_valid3 = 3'b111;
        y_ready3  = 1'b1;
        #1;
        chk("n3_sel3_in_ready", 32'(in_ready3), 32'd0);
        @(posedge clk);
        #1;
        chk("n3_sel3_y_valid", 32'(y_valid3), 32'd0);
        sel3 = 2'd2;
        #1;
        chk("n3_sel2_in_ready", 32'(in_ready3), 32'b100);
        @(posedge clk);
        #1;
        chk("n3_sel2_y_valid", 32'(y_valid3), 32'd1);
        chk("n3_sel2_y_ch", 32'(y_ch3), 32'd2);
        chk("n3_sel2_y_data", 32'(y_data3), 32'hB2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
